// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_unit
// Purpose  : Iterative restoring divider for UDIV/SDIV in the execute stage.
//            Produces {remainder, quotient} one quotient bit per cycle and
//            holds a stall request to the hazard unit while it works.
// Ports    : clk         - system clock, rising edge
//            reset       - asynchronous active-low reset
//            start       - request a division (sampled only in IDLE)
//            is_signed   - 1 = SDIV, 0 = UDIV (latched with start)
//            dividend    - numerator (latched with start)
//            divisor     - denominator (latched with start)
//            flush       - abort an in-flight operation
//            stall_req   - stall request to the hazard unit
//            busy        - high while iterating
//            done        - one-cycle pulse, result valid
//            result      - {remainder, quotient}
//            div_by_zero - set when the last completed operation had divisor 0
// Revision : 1.0 - initial release
// ============================================================================
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    input  logic               flush,
    output logic               stall_req,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]   r_rem;      // partial remainder, always < |divisor|
    logic [WIDTH-1:0]   r_quo;      // dividend bits shift out of the MSB, quotient bits shift in at the LSB
    logic [WIDTH-1:0]   r_dvs;      // |divisor|
    logic               r_neg_q;
    logic               r_neg_r;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_nx;
    logic [WIDTH-1:0]   w_quo_nx;
    logic [WIDTH-1:0]   w_q_fin;
    logic [WIDTH-1:0]   w_r_fin;

    // Operand magnitudes (two's complement negation modulo 2^WIDTH).
    assign w_a_neg  = is_signed & dividend[WIDTH-1];
    assign w_b_neg  = is_signed & divisor[WIDTH-1];
    assign w_a_mag  = w_a_neg ? (~dividend + 1'b1) : dividend;
    assign w_b_mag  = w_b_neg ? (~divisor + 1'b1) : divisor;

    // One restoring step. The shifted remainder is WIDTH+1 bits so the
    // compare never overflows; the top bit of the difference is the borrow.
    assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_dvs};
    assign w_ge     = ~w_diff[WIDTH];
    assign w_rem_nx = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    assign w_quo_nx = {r_quo[WIDTH-2:0], w_ge};

    // Truncation toward zero: quotient negative when signs differ,
    // remainder follows the sign of the dividend.
    assign w_q_fin  = r_neg_q ? (~w_quo_nx + 1'b1) : w_quo_nx;
    assign w_r_fin  = r_neg_r ? (~w_rem_nx + 1'b1) : w_rem_nx;

    assign stall_req = ((r_state == S_IDLE) & start & ~flush) | (r_state == S_CALC);
    assign busy      = (r_state == S_CALC);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !flush) begin
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_quo   <= w_a_mag;
                        r_dvs   <= w_b_mag;
                        r_rem   <= '0;
                        if (divisor == '0) begin
                            // Zero divide finishes immediately with the raw dividend as remainder.
                            result      <= {dividend, {WIDTH{1'b0}}};
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            r_state     <= S_FIN;
                        end else begin
                            r_count <= CNT_W'(WIDTH);
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        r_count <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_rem   <= w_rem_nx;
                        r_quo   <= w_quo_nx;
                        r_count <= r_count - 1'b1;
                        if (r_count == CNT_W'(1)) begin
                            // Last bit: capture the sign-corrected result so it is
                            // valid during the FIN cycle alongside done.
                            result      <= {w_r_fin, w_q_fin};
                            div_by_zero <= 1'b0;
                            done        <= 1'b1;
                            r_state     <= S_FIN;
                        end
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
